rvh_ptw_req_sched: RTL and testbench

//  Shares the single page-table walker between ITLB and DTLB miss requests. Arbitrates

---
 rtl/rvh_ptw_req_sched.sv | 145 ++++++++++++++
 tb/tb_rvh_ptw_req_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_ptw_req_sched.sv
// Shares one page-table walker between ITLB and DTLB misses: priority arbitration with
// anti-starvation, request hold until PTW accept, single outstanding walk, response routing.
module rvh_ptw_req_sched #(
    parameter int unsigned VPN_WIDTH      = 27,
    parameter int unsigned TRANS_ID_WIDTH = 2,
    parameter int unsigned PTE_WIDTH      = 64,
    parameter bit          DTLB_PRIOR     = 1'b1,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush_i,
    input  logic                      itlb_miss_req_vld_i,
    input  logic [VPN_WIDTH-1:0]      itlb_miss_req_vpn_i,
    input  logic [TRANS_ID_WIDTH-1:0] itlb_miss_req_trans_id_i,
    output logic                      itlb_miss_req_rdy_o,
    input  logic                      dtlb_miss_req_vld_i,
    input  logic [VPN_WIDTH-1:0]      dtlb_miss_req_vpn_i,
    input  logic [TRANS_ID_WIDTH-1:0] dtlb_miss_req_trans_id_i,
    output logic                      dtlb_miss_req_rdy_o,
    output logic                      ptw_req_vld_o,
    output logic [VPN_WIDTH-1:0]      ptw_req_vpn_o,
    input  logic                      ptw_req_rdy_i,
    input  logic                      ptw_resp_vld_i,
    input  logic [PTE_WIDTH-1:0]      ptw_resp_pte_i,
    input  logic                      ptw_resp_fault_i,
    output logic                      itlb_resp_vld_o,
    output logic                      dtlb_resp_vld_o,
    output logic [TRANS_ID_WIDTH-1:0] tlb_resp_trans_id_o,
    output logic [PTE_WIDTH-1:0]      tlb_resp_pte_o,
    output logic                      tlb_resp_fault_o
);

    localparam int unsigned CNT_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WALK  = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          starve_cnt, starve_cnt_nxt;
    logic                      kill, kill_nxt;
    logic [VPN_WIDTH-1:0]      vpn_q;
    logic [TRANS_ID_WIDTH-1:0] tid_q;
    logic                      src_dtlb_q;
    logic                      grant, grant_dtlb;
    logic                      both_vld, starve_hit, pick_dtlb;
    logic                      itlb_rdy, dtlb_rdy;

    // Arbitration: forced low-priority win once its loss streak reaches the limit
    always_comb begin
        both_vld   = itlb_miss_req_vld_i & dtlb_miss_req_vld_i;
        starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == CNT_W'(STARVE_LIMIT));
        if (both_vld) begin
            pick_dtlb = starve_hit ? !DTLB_PRIOR : DTLB_PRIOR;
        end else begin
            pick_dtlb = dtlb_miss_req_vld_i;
        end
    end

    always_comb begin
        state_nxt      = state;
        kill_nxt       = kill;
        starve_cnt_nxt = starve_cnt;
        grant          = 1'b0;
        grant_dtlb     = 1'b0;
        itlb_rdy       = 1'b0;
        dtlb_rdy       = 1'b0;
        ptw_req_vld_o   = 1'b0;
        itlb_resp_vld_o = 1'b0;
        dtlb_resp_vld_o = 1'b0;
        case (state)
            IDLE: begin
                if (!flush_i && (itlb_miss_req_vld_i || dtlb_miss_req_vld_i)) begin
                    grant      = 1'b1;
                    grant_dtlb = pick_dtlb;
                    dtlb_rdy   = pick_dtlb;
                    itlb_rdy   = !pick_dtlb;
                    state_nxt  = ISSUE;
                    if (pick_dtlb != DTLB_PRIOR) begin
                        starve_cnt_nxt = '0;
                    end else if (both_vld && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                        starve_cnt_nxt = starve_cnt + CNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                ptw_req_vld_o = 1'b1;
                if (ptw_req_rdy_i) begin
                    state_nxt = WALK;
                    kill_nxt  = flush_i;
                end else if (flush_i) begin
                    state_nxt = IDLE;
                end
            end
            WALK: begin
                if (ptw_resp_vld_i) begin
                    state_nxt       = IDLE;
                    kill_nxt        = 1'b0;
                    itlb_resp_vld_o = !src_dtlb_q && !(kill || flush_i);
                    dtlb_resp_vld_o = src_dtlb_q && !(kill || flush_i);
                end else if (flush_i) begin
                    kill_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are masked while reset is held so no requester sees a phantom accept
    assign itlb_miss_req_rdy_o = itlb_rdy & rstn;
    assign dtlb_miss_req_rdy_o = dtlb_rdy & rstn;
    assign ptw_req_vpn_o       = vpn_q;
    assign tlb_resp_trans_id_o = tid_q;
    assign tlb_resp_pte_o      = ptw_resp_pte_i;
    assign tlb_resp_fault_o    = ptw_resp_fault_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            starve_cnt <= '0;
            kill       <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            kill       <= kill_nxt;
        end
    end

    // Winner's request captured at grant and held for the life of the walk
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vpn_q      <= '0;
            tid_q      <= '0;
            src_dtlb_q <= 1'b0;
        end else if (grant) begin
            vpn_q      <= grant_dtlb ? dtlb_miss_req_vpn_i : itlb_miss_req_vpn_i;
            tid_q      <= grant_dtlb ? dtlb_miss_req_trans_id_i : itlb_miss_req_trans_id_i;
            src_dtlb_q <= grant_dtlb;
        end
    end

endmodule

// File: tb/tb_rvh_ptw_req_sched.sv
// Scoreboard bench for rvh_ptw_req_sched: default instance plus an ITLB-priority,
// no-anti-starvation instance.
module tb_rvh_ptw_req_sched;

    typedef struct packed {
        logic        src;
        logic [1:0]  tid;
        logic [63:0] pte;
        logic        fault;
    } resp_t;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        i_vld, d_vld, i_rdy, d_rdy;
    logic [26:0] i_vpn, d_vpn, req_vpn;
    logic [1:0]  i_tid, d_tid, resp_tid;
    logic        req_vld, req_rdy, p_vld, p_fault;
    logic [63:0] p_pte, resp_pte;
    logic        i_resp, d_resp, resp_fault;

    logic        b_i_vld, b_d_vld, b_i_rdy, b_d_rdy;
    logic [26:0] b_i_vpn, b_d_vpn, b_req_vpn;
    logic [1:0]  b_i_tid, b_d_tid, b_resp_tid;
    logic        b_req_vld, b_req_rdy, b_p_vld;
    logic [63:0] b_resp_pte;
    logic        b_i_resp, b_d_resp, b_resp_fault;

    int          checks;
    int          failures;
    int          b_grants;
    bit          q_grant[$];
    logic [26:0] q_req[$];
    resp_t       q_resp[$];

    rvh_ptw_req_sched u_dut (
        .clk(clk), .rstn(rstn), .flush_i(flush),
        .itlb_miss_req_vld_i(i_vld), .itlb_miss_req_vpn_i(i_vpn),
        .itlb_miss_req_trans_id_i(i_tid), .itlb_miss_req_rdy_o(i_rdy),
        .dtlb_miss_req_vld_i(d_vld), .dtlb_miss_req_vpn_i(d_vpn),
        .dtlb_miss_req_trans_id_i(d_tid), .dtlb_miss_req_rdy_o(d_rdy),
        .ptw_req_vld_o(req_vld), .ptw_req_vpn_o(req_vpn), .ptw_req_rdy_i(req_rdy),
        .ptw_resp_vld_i(p_vld), .ptw_resp_pte_i(p_pte), .ptw_resp_fault_i(p_fault),
        .itlb_resp_vld_o(i_resp), .dtlb_resp_vld_o(d_resp),
        .tlb_resp_trans_id_o(resp_tid), .tlb_resp_pte_o(resp_pte),
        .tlb_resp_fault_o(resp_fault)
    );

    rvh_ptw_req_sched #(.DTLB_PRIOR(1'b0), .STARVE_LIMIT(0)) u_itlb_prio (
        .clk(clk), .rstn(rstn), .flush_i(1'b0),
        .itlb_miss_req_vld_i(b_i_vld), .itlb_miss_req_vpn_i(b_i_vpn),
        .itlb_miss_req_trans_id_i(b_i_tid), .itlb_miss_req_rdy_o(b_i_rdy),
        .dtlb_miss_req_vld_i(b_d_vld), .dtlb_miss_req_vpn_i(b_d_vpn),
        .dtlb_miss_req_trans_id_i(b_d_tid), .dtlb_miss_req_rdy_o(b_d_rdy),
        .ptw_req_vld_o(b_req_vld), .ptw_req_vpn_o(b_req_vpn), .ptw_req_rdy_i(b_req_rdy),
        .ptw_resp_vld_i(b_p_vld), .ptw_resp_pte_i(64'h9), .ptw_resp_fault_i(1'b0),
        .itlb_resp_vld_o(b_i_resp), .dtlb_resp_vld_o(b_d_resp),
        .tlb_resp_trans_id_o(b_resp_tid), .tlb_resp_pte_o(b_resp_pte),
        .tlb_resp_fault_o(b_resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input bit ok,
                                input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Monitor: pop and compare whenever the default instance presents an output event
    always @(negedge clk) begin
        bit          e_src;
        logic [26:0] e_vpn;
        resp_t       e_resp, a_resp;
        if (i_rdy || d_rdy) begin
            if (q_grant.size() == 0) begin
                chk("grant_unexpected", 1'b0, {i_rdy, d_rdy}, 0);
            end else begin
                e_src = q_grant.pop_front();
                chk("grant_src", (i_rdy != d_rdy) && (d_rdy == e_src), {i_rdy, d_rdy},
                    {!e_src, e_src});
            end
        end
        if (req_vld && req_rdy) begin
            if (q_req.size() == 0) begin
                chk("ptw_req_unexpected", 1'b0, req_vpn, 0);
            end else begin
                e_vpn = q_req.pop_front();
                chk("ptw_req_vpn", req_vpn == e_vpn, req_vpn, e_vpn);
            end
        end
        if (i_resp || d_resp) begin
            a_resp = '{src: d_resp, tid: resp_tid, pte: resp_pte, fault: resp_fault};
            if (q_resp.size() == 0) begin
                chk("resp_unexpected", 1'b0, {i_resp, d_resp, a_resp}, 0);
            end else begin
                e_resp = q_resp.pop_front();
                chk("tlb_resp", (i_resp != d_resp) && (a_resp == e_resp),
                    {i_resp, d_resp, a_resp}, {!e_resp.src, e_resp.src, e_resp});
            end
        end
        if (b_i_rdy || b_d_rdy) begin
            b_grants++;
            chk("b_grant_itlb", b_i_rdy && !b_d_rdy, {b_i_rdy, b_d_rdy}, 2'b10);
        end
        if (b_i_resp || b_d_resp) begin
            chk("b_resp_itlb", b_i_resp && !b_d_resp && (b_resp_tid == 2'd1),
                {b_i_resp, b_d_resp, b_resp_tid}, {2'b10, 2'd1});
        end
    end

    task automatic expect_miss(input bit src, input logic [26:0] vpn, input logic [1:0] tid,
                               input logic [63:0] pte, input bit fault);
        q_grant.push_back(src);
        q_req.push_back(vpn);
        q_resp.push_back('{src: src, tid: tid, pte: pte, fault: fault});
    endtask

    // One complete miss; the other requester is held valid during PTW back-pressure
    task automatic run_miss(input bit src, input logic [26:0] vpn, input logic [1:0] tid,
                            input int rdy_dly, input int resp_dly,
                            input logic [63:0] pte, input bit fault);
        expect_miss(src, vpn, tid, pte, fault);
        @(posedge clk); #1;
        if (src) begin d_vld = 1'b1; d_vpn = vpn; d_tid = tid; end
        else     begin i_vld = 1'b1; i_vpn = vpn; i_tid = tid; end
        req_rdy = 1'b0;
        @(posedge clk); #1;
        i_vld = 1'b0; d_vld = 1'b0;
        for (int k = 0; k < rdy_dly; k++) begin
            if (src) i_vld = 1'b1; else d_vld = 1'b1;
            @(negedge clk);
            chk("stall_hold", req_vld && (req_vpn == vpn) && !i_rdy && !d_rdy,
                {req_vld, i_rdy, d_rdy, req_vpn}, {3'b100, vpn});
            @(posedge clk); #1;
        end
        i_vld = 1'b0; d_vld = 1'b0;
        req_rdy = 1'b1;
        @(posedge clk); #1;
        req_rdy = 1'b0;
        for (int k = 0; k < resp_dly; k++) begin
            @(posedge clk); #1;
        end
        p_vld = 1'b1; p_pte = pte; p_fault = fault;
        @(posedge clk); #1;
        p_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0; b_grants = 0;
        rstn = 1'b0; flush = 1'b0;
        i_vld = 1'b1; d_vld = 1'b1; i_vpn = 27'h5; d_vpn = 27'h6; i_tid = 2'd1; d_tid = 2'd2;
        req_rdy = 1'b1; p_vld = 1'b1; p_pte = 64'h0; p_fault = 1'b0;
        b_i_vld = 1'b0; b_d_vld = 1'b0; b_i_vpn = 27'h111; b_d_vpn = 27'h222;
        b_i_tid = 2'd1; b_d_tid = 2'd2; b_req_rdy = 1'b0; b_p_vld = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {i_rdy, d_rdy, req_vld, i_resp, d_resp, resp_tid, req_vpn} == 0,
            {i_rdy, d_rdy, req_vld, i_resp, d_resp, resp_tid, req_vpn}, 0);
        @(posedge clk); #1;
        i_vld = 1'b0; d_vld = 1'b0; req_rdy = 1'b0; p_vld = 1'b0;
        rstn = 1'b1;

        run_miss(1'b1, 27'h1234, 2'd2, 0, 2, 64'hABCD, 1'b0);
        run_miss(1'b0, 27'h7_0000, 2'd1, 5, 1, 64'hDEAD_BEEF_0000_1111, 1'b1);

        // Both requesters valid every cycle: D,D,D,D,I repeating
        for (int g = 0; g < 10; g++) begin
            if (g % 5 == 4) expect_miss(1'b0, 27'h0AAAA, 2'd1, 64'h55, 1'b0);
            else            expect_miss(1'b1, 27'h0BBBB, 2'd3, 64'h55, 1'b0);
        end
        @(posedge clk); #1;
        i_vld = 1'b1; i_vpn = 27'h0AAAA; i_tid = 2'd1;
        d_vld = 1'b1; d_vpn = 27'h0BBBB; d_tid = 2'd3;
        req_rdy = 1'b1; p_vld = 1'b1; p_pte = 64'h55; p_fault = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        i_vld = 1'b0; d_vld = 1'b0; req_rdy = 1'b0; p_vld = 1'b0;

        // Flush while PTW is not ready: request withdrawn
        q_grant.push_back(1'b1);
        @(posedge clk); #1;
        d_vld = 1'b1; d_vpn = 27'h42; d_tid = 2'd0;
        @(posedge clk); #1;
        d_vld = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_issue_vld", req_vld == 1'b1, req_vld, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_issue_idle", req_vld == 1'b0, req_vld, 0);

        // Flush during walk: response consumed silently
        q_grant.push_back(1'b0);
        q_req.push_back(27'h99);
        @(posedge clk); #1;
        i_vld = 1'b1; i_vpn = 27'h99; i_tid = 2'd3; req_rdy = 1'b1;
        @(posedge clk); #1;
        i_vld = 1'b0;
        @(posedge clk); #1;
        req_rdy = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        p_vld = 1'b1; p_pte = 64'h77;
        @(negedge clk);
        chk("flush_walk_resp", !i_resp && !d_resp, {i_resp, d_resp}, 0);
        @(posedge clk); #1;
        p_vld = 1'b0;
        run_miss(1'b1, 27'h0F00, 2'd1, 0, 0, 64'h1234_5678, 1'b0);

        // Spurious PTW response while idle
        @(posedge clk); #1;
        p_vld = 1'b1;
        @(negedge clk);
        chk("spurious_resp", !i_resp && !d_resp, {i_resp, d_resp}, 0);
        @(posedge clk); #1;
        p_vld = 1'b0;

        // Reset in the middle of a walk
        q_grant.push_back(1'b1);
        q_req.push_back(27'h333);
        @(posedge clk); #1;
        d_vld = 1'b1; d_vpn = 27'h333; d_tid = 2'd1; req_rdy = 1'b1;
        @(posedge clk); #1;
        d_vld = 1'b0;
        @(posedge clk); #1;
        req_rdy = 1'b0; rstn = 1'b0; p_vld = 1'b1; p_pte = 64'hBAD;
        @(negedge clk);
        chk("reset_walk_outputs", {i_rdy, d_rdy, req_vld, i_resp, d_resp, resp_tid, req_vpn} == 0,
            {i_rdy, d_rdy, req_vld, i_resp, d_resp, resp_tid, req_vpn}, 0);
        @(posedge clk); #1;
        p_vld = 1'b0; rstn = 1'b1;
        run_miss(1'b0, 27'h1_2345, 2'd2, 1, 0, 64'hCAFE, 1'b0);

        // ITLB-priority instance without anti-starvation: ITLB always wins
        @(posedge clk); #1;
        b_i_vld = 1'b1; b_d_vld = 1'b1; b_req_rdy = 1'b1; b_p_vld = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        b_i_vld = 1'b0; b_d_vld = 1'b0; b_req_rdy = 1'b0; b_p_vld = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("b_grant_count", b_grants == 10, b_grants, 10);
        chk("queues_drained", (q_grant.size() + q_req.size() + q_resp.size()) == 0,
            {q_grant.size(), q_req.size(), q_resp.size()}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
